// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the round-robin DEMUX scheduler.
package demux_sched_pkg;

  typedef enum logic [1:0] {StIdle, StArb, StBurst} state_e;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  // Width that holds 0..max_val-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Rotating-priority picker: first request strictly after ptr_i, wrapping back to ptr_i itself.
module demux_rr_pick
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  idx_o
);

  logic [SEL_W-1:0] cand;

  // Walk from farthest to nearest so the nearest hit after ptr_i wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler sharing one valid/ready input stream among 8 DEMUX sink channels.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  input  logic                  Last_In,
  output logic                  Ready_Out,
  input  logic [NUM_CH-1:0]     Ch_Mask_In,
  input  logic [NUM_CH-1:0]     Ch_Ready_In,
  output logic                  Demux_Enable_Out,
  output logic [SEL_W-1:0]      Demux_Select_Out,
  output logic [DATA_WIDTH-1:0] Demux_Data_Out,
  output logic                  Beat_Strobe_Out,
  output logic                  Abort_Out
);

  localparam int unsigned BeatW  = cnt_w(BURST_LEN);
  localparam int unsigned StallW = cnt_w(STALL_LIMIT + 1);
  localparam logic [BeatW-1:0]  BeatLast = BeatW'(BURST_LEN - 1);
  localparam logic [StallW-1:0] StallTop = StallW'(STALL_LIMIT - 1);

  state_e                state_q;
  logic [SEL_W-1:0]      sel_q, ptr_q;
  logic [BeatW-1:0]      beat_q;
  logic [StallW-1:0]     stall_q;
  logic                  en_q, strobe_q, abort_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic             pick_hit;
  logic [SEL_W-1:0] pick_idx;
  logic             ch_mask, ch_rdy, xfer;

  demux_rr_pick u_pick (
    .req_i (Ch_Mask_In & Ch_Ready_In),
    .ptr_i (ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  assign ch_mask   = Ch_Mask_In[sel_q];
  assign ch_rdy    = Ch_Ready_In[sel_q];
  assign Ready_Out = (state_q == StBurst) & Enable_In & ch_mask & ch_rdy;
  assign xfer      = Valid_In & Ready_Out;

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      ptr_q    <= SEL_W'(NUM_CH - 1);
      beat_q   <= '0;
      stall_q  <= '0;
      en_q     <= 1'b0;
      strobe_q <= 1'b0;
      abort_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      strobe_q <= xfer;
      data_q   <= xfer ? Data_In : '0;
      abort_q  <= 1'b0;
      unique case (state_q)
        StIdle: if (Enable_In) state_q <= StArb;
        StArb: begin
          if (!Enable_In) begin
            state_q <= StIdle;
          end else if (pick_hit) begin
            sel_q   <= pick_idx;
            en_q    <= 1'b1;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (!Enable_In) begin
            // Pointer is kept so re-enable resumes the rotation.
            state_q <= StIdle;
            en_q    <= 1'b0;
            beat_q  <= '0;
            stall_q <= '0;
          end else if (!ch_mask) begin
            ptr_q   <= sel_q;
            state_q <= StArb;
            en_q    <= 1'b0;
            beat_q  <= '0;
            stall_q <= '0;
          end else if (xfer) begin
            stall_q <= '0;
            if (beat_q == BeatLast || Last_In) begin
              ptr_q   <= sel_q;
              state_q <= StArb;
              en_q    <= 1'b0;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end else if (!ch_rdy) begin
            if (stall_q == StallTop) begin
              abort_q <= 1'b1;
              ptr_q   <= sel_q;
              state_q <= StArb;
              en_q    <= 1'b0;
              beat_q  <= '0;
              stall_q <= '0;
            end else begin
              stall_q <= stall_q + 1'b1;
            end
          end else begin
            stall_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Demux_Enable_Out = en_q;
  assign Demux_Select_Out = sel_q;
  assign Demux_Data_Out   = data_q;
  assign Beat_Strobe_Out  = strobe_q;
  assign Abort_Out        = abort_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench for demux_rr_scheduler against a transaction-level round-robin model.
module tb_demux_rr_scheduler;

  localparam int DW = 4;
  localparam int BL = 4;
  localparam int SL = 15;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1, en_in = 1'b0, valid_in = 1'b0, last_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [7:0]    mask_in = '0, rdy_in = '0;
  logic          ready_out, den_out, strobe_out, abort_out;
  logic [2:0]    sel_out;
  logic [DW-1:0] data_out;

  always #5 clk = ~clk;

  demux_rr_scheduler #(
    .DATA_WIDTH  (DW),
    .BURST_LEN   (BL),
    .STALL_LIMIT (SL)
  ) dut (
    .Clock_In         (clk),
    .Reset_In         (rst_in),
    .Enable_In        (en_in),
    .Data_In          (data_in),
    .Valid_In         (valid_in),
    .Last_In          (last_in),
    .Ready_Out        (ready_out),
    .Ch_Mask_In       (mask_in),
    .Ch_Ready_In      (rdy_in),
    .Demux_Enable_Out (den_out),
    .Demux_Select_Out (sel_out),
    .Demux_Data_Out   (data_out),
    .Beat_Strobe_Out  (strobe_out),
    .Abort_Out        (abort_out)
  );

  typedef struct {
    int            tag;
    logic          strobe;
    logic          abort;
    int            sel;
    logic [DW-1:0] data;
  } ev_t;

  ev_t q[$];
  int  vectors = 0;
  int  errors  = 0;
  int  cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: mode 0 idle, 1 searching, 2 serving channel m_sel.
  int m_mode = 0, m_ptr = 7, m_sel = 0, m_beats = 0, m_stall = 0;
  bit prev_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 7; m_sel = 0; m_beats = 0; m_stall = 0;
  endtask

  task automatic leave_burst();
    m_ptr = m_sel; m_mode = 1; m_beats = 0; m_stall = 0;
  endtask

  task automatic drive(input bit rst, input bit en, input bit vld, input bit lst,
                       input logic [7:0] mask, input logic [7:0] rdy, input logic [DW-1:0] d);
    bit m_ready, xfer;
    @(posedge clk);
    #1;
    rst_in = rst; en_in = en; valid_in = vld; last_in = lst;
    mask_in = mask; rdy_in = rdy; data_in = d;
    #1;
    if (prev_rst) begin
      check("reset_sel", 32'(sel_out), 32'(m_sel));
      check("reset_strobe", 32'(strobe_out), 0);
      check("reset_abort", 32'(abort_out), 0);
      check("reset_data", 32'(data_out), 0);
    end
    m_ready = (m_mode == 2) && en && mask[m_sel] && rdy[m_sel];
    xfer    = vld && m_ready;
    check("ready_out", 32'(ready_out), 32'(m_ready));
    check("demux_enable", 32'(den_out), 32'(m_mode == 2));
    if (m_mode == 2) check("demux_select", 32'(sel_out), 32'(m_sel));
    if (rst) begin
      model_reset();
    end else begin
      if (xfer) q.push_back('{tag: cyc + 1, strobe: 1'b1, abort: 1'b0, sel: m_sel, data: d});
      case (m_mode)
        0: if (en) m_mode = 1;
        1: begin
          if (!en) m_mode = 0;
          else begin
            for (int k = 1; k <= 8; k++) begin
              int c;
              c = (m_ptr + k) % 8;
              if (mask[c] && rdy[c]) begin
                m_sel = c; m_mode = 2; m_beats = 0; m_stall = 0;
                break;
              end
            end
          end
        end
        default: begin
          if (!en) begin
            m_mode = 0; m_beats = 0; m_stall = 0;
          end else if (!mask[m_sel]) begin
            leave_burst();
          end else if (xfer) begin
            m_stall = 0;
            m_beats++;
            if (m_beats == BL || lst) leave_burst();
          end else if (!rdy[m_sel]) begin
            m_stall++;
            if (m_stall == SL) begin
              q.push_back('{tag: cyc + 1, strobe: 1'b0, abort: 1'b1, sel: m_sel, data: '0});
              leave_burst();
            end
          end else begin
            m_stall = 0;
          end
        end
      endcase
    end
    prev_rst = rst;
  endtask

  task automatic run(input int n, input bit en, input bit vld,
                     input logic [7:0] mask, input logic [7:0] rdy);
    for (int i = 0; i < n; i++) drive(1'b0, en, vld, 1'b0, mask, rdy, DW'($urandom));
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or an abort.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (strobe_out === 1'b1 || abort_out === 1'b1) begin
          if (q.size() == 0) begin
            check("unexpected_event", {30'd0, strobe_out, abort_out}, 0);
          end else begin
            ev_t e;
            e = q.pop_front();
            check("event_kind", {30'd0, strobe_out, abort_out}, {30'd0, e.strobe, e.abort});
            check("event_cycle", 32'(cyc), 32'(e.tag));
            check("event_sel", 32'(sel_out), 32'(e.sel));
            if (e.strobe) check("event_data", 32'(data_out), 32'(e.data));
          end
        end else begin
          check("idle_data_zero", 32'(data_out), 0);
        end
        while (q.size() > 0 && q[0].tag < cyc) begin
          ev_t m;
          m = q.pop_front();
          check("missed_event", 0, {30'd0, m.strobe, m.abort});
        end
      end
    end
  end

  initial begin
    do_reset();
    // Full rotation with all channels eligible.
    run(50, 1'b1, 1'b1, 8'hFF, 8'hFF);
    // Two eligible channels alternate.
    run(30, 1'b1, 1'b1, 8'b0010_0100, 8'hFF);
    // Stall timeout on channel 3, then the rotation moves on to channel 4.
    do_reset();
    run(4, 1'b1, 1'b0, 8'h08, 8'h08);
    run(20, 1'b1, 1'b1, 8'hFF, 8'hF7);
    // Early end with Last on the second word of channel 1.
    do_reset();
    for (int i = 0; i < 14; i++)
      drive(1'b0, 1'b1, 1'b1, (m_mode == 2 && m_sel == 1 && m_beats == 1), 8'h06, 8'hFF,
            DW'($urandom));
    // Enable drop mid-burst and resume.
    run(6, 1'b1, 1'b1, 8'hFF, 8'hFF);
    run(3, 1'b0, 1'b1, 8'hFF, 8'hFF);
    run(10, 1'b1, 1'b1, 8'hFF, 8'hFF);
    // Mask drop on the served channel.
    run(3, 1'b1, 1'b1, 8'hFF, 8'hFF);
    run(2, 1'b1, 1'b1, 8'h00, 8'hFF);
    // Reset mid-burst.
    run(5, 1'b1, 1'b1, 8'hFF, 8'hFF);
    do_reset();
    run(8, 1'b1, 1'b1, 8'hFF, 8'hFF);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] mask, rdy;
      int pick;
      pick = $urandom_range(0, 3);
      mask = (pick == 0) ? 8'hFF : (pick == 1) ? 8'b0010_0100 : 8'($urandom | $urandom);
      rdy  = 8'($urandom | $urandom);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 6) == 0), mask, rdy,
            DW'($urandom));
    end
    run(6, 1'b0, 1'b0, 8'h00, 8'h00);
    check("scoreboard_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
